decoder_3to8_pulse: RTL
=======================

Name: decoder_3to8_pulse

Overview:
- Sequenced 3-to-8 decoder. It is the receive/drive end of the one-hot select path whose codes are produced by the team's 8-to-3 encoder.
- Accepts 3-bit codes over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Drives each code as a registered one-hot pulse of fixed length, followed by an idle gap.
- Used to strobe 8 select/enable lines in order, one code at a time, without glitches.

Parameters:
- PULSE_LEN, 4: cycles each one-hot value is held. Legal range 1..255.
- GAP_LEN, 1: all-zero cycles inserted after each pulse. Legal range 0..255.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_code is valid
- in_ready  output  1  block can accept a code this cycle
- in_code  input  3  binary code 0..7
- en  input  1  allows new codes to be popped from the FIFO
- out_onehot  output  8  registered one-hot output; all-zero when not driving
- out_active  output  1  high exactly while out_onehot is non-zero
- busy  output  1  high when FSM is not IDLE or FIFO is not empty

Behaviour:
- Reset (rst_n low): effect is immediate and asynchronous.
  - FIFO emptied; FSM goes to IDLE; counter cleared.
  - out_onehot=8'h00, out_active=0, busy=0, in_ready=0.
  - in_ready goes to 1 on the first clk edge after rst_n deasserts.
- Reset mid-pulse: output drops to zero at once; the buffered codes and the code in flight are discarded.
- Accept rule: a code is accepted on a rising edge where in_valid && in_ready.
  - in_ready = FIFO not full.
  - in_ready must not depend combinationally on in_valid.
- FIFO: 2 entries, first in first out.
  - Push and pop in the same cycle are allowed at any occupancy, including 0.
  - At occupancy 0 the pushed code is written and the pop does not occur that cycle (no bypass).
  - At occupancy 2, in_ready=0. A pop that cycle raises in_ready on the next cycle.
- FSM states:
  - IDLE: out_onehot=0. If FIFO non-empty and en=1: pop, set out_onehot <= 8'b1 << code, load counter=PULSE_LEN-1, go to DRIVE.
  - DRIVE: hold out_onehot. When counter==0:
    - If GAP_LEN>0: clear output, load counter=GAP_LEN-1, go to GAP.
    - If GAP_LEN==0: clear output and go to IDLE.
    - Otherwise: decrement counter.
  - GAP: out_onehot=0. When counter==0, go to IDLE. Otherwise decrement.
- Latency:
  - Code accepted at edge k with FIFO empty, FSM IDLE and en=1: out_onehot is valid after edge k+1.
  - It stays valid for exactly PULSE_LEN cycles.
- Pulse spacing, back-to-back, en=1:
  - Pulse-start to pulse-start = PULSE_LEN + GAP_LEN + 1 cycles (one IDLE cycle always precedes a pop).
  - With GAP_LEN=0 the zero gap is exactly one cycle.
- en rules:
  - en is sampled only in IDLE.
  - Deasserting en never truncates a pulse or gap in progress.
  - With en=0 the FIFO fills to 2 and then backpressures.
- Output register rules:
  - out_onehot never has more than one bit set.
  - out_onehot changes only on clock edges and never goes directly from one non-zero value to another.
- busy: combinational OR of (state!=IDLE) and (FIFO count!=0).
- Counters: width $clog2(max(PULSE_LEN,GAP_LEN)+1), minimum 1 bit. No wrap-around is reachable.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release → out_onehot=0, busy=0, in_ready=1 one edge after release. Assert rst_n=0 asynchronously mid-DRIVE → out_onehot=0 before the next edge.
- Single code, PULSE_LEN=4, GAP_LEN=1, en=1: push code 5 at edge k → out_onehot=8'h20 after edges k+1..k+4, 0 after k+5, busy=0 after k+6.
- All codes: push 0..7 back-to-back holding in_valid → outputs 01,02,04,08,10,20,40,80 in order, each 4 cycles, pulse starts 6 cycles apart, in_ready toggling, no code lost or duplicated.
- Backpressure: en=0, push 3, 6, then offer 1 → in_ready=0 after the second push, code 1 held off. Set en=1 → 08, then 40, then 02 driven.
- en drop mid-pulse: deassert en during the second DRIVE cycle of code 2 → pulse 04 still lasts the full 4 cycles; the next code waits until en=1.
- Boundary parameters: PULSE_LEN=1, GAP_LEN=0, codes 7 then 7 → 80, 00, 80 on consecutive cycles. Simultaneous push/pop at FIFO count 1 keeps count 1 and preserves order.

Source files
------------

// File: rtl/decoder_3to8_pulse.sv
// rtl/decoder_3to8_pulse.sv - sequenced 3-to-8 decoder with 2-entry code FIFO and fixed-length one-hot pulses
module decoder_3to8_pulse #(
   parameter int unsigned PULSE_LEN = 4,
   parameter int unsigned GAP_LEN   = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_code,
   input  logic       en,
   output logic [7:0] out_onehot,
   output logic       out_active,
   output logic       busy
);

   localparam int unsigned MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
   localparam int CW = ($clog2(MAX_LEN + 1) < 1) ? 1 : $clog2(MAX_LEN + 1);
   localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
   localparam logic [CW-1:0] GAP_LOAD   = (GAP_LEN > 0) ? CW'(GAP_LEN - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_GAP
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [7:0]    onehot_q, onehot_n;

   logic [2:0] mem [2];
   logic       rd_ptr, wr_ptr;
   logic [1:0] count;
   logic       ready_q;
   logic       push, pop;

   // ready_q keeps in_ready low through reset and for the edge that releases it
   assign in_ready = ready_q && (count != 2'd2);
   assign push     = in_valid && in_ready;
   assign pop      = (state == ST_IDLE) && en && (count != 2'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr  <= 1'b0;
         wr_ptr  <= 1'b0;
         count   <= 2'd0;
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_code;
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      onehot_n = onehot_q;
      unique case (state)
         ST_IDLE: begin
            onehot_n = 8'h00;
            if (pop) begin
               onehot_n = 8'(1) << mem[rd_ptr];
               cnt_n    = PULSE_LOAD;
               state_n  = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (cnt == '0) begin
               onehot_n = 8'h00;
               if (GAP_LEN > 0) begin
                  cnt_n   = GAP_LOAD;
                  state_n = ST_GAP;
               end else begin
                  state_n = ST_IDLE;
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         ST_GAP: begin
            onehot_n = 8'h00;
            if (cnt == '0) state_n = ST_IDLE;
            else           cnt_n   = cnt - 1'b1;
         end
         default: begin
            onehot_n = 8'h00;
            state_n  = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         onehot_q <= 8'h00;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         onehot_q <= onehot_n;
      end
   end

   assign out_onehot = onehot_q;
   assign out_active = |onehot_q;
   assign busy       = (state != ST_IDLE) || (count != 2'd0);

endmodule
